// File: rtl/branch_pkg.sv
// Shared types for the branch resolution stage: instruction kinds, branch
// condition encodings and the 2-bit history counter with its update rule.
package branch_pkg;

  typedef enum logic [1:0] {
    BRANCH = 2'b00,
    JAL    = 2'b01,
    JALR   = 2'b10,
    RSVD   = 2'b11
  } kind_t;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  typedef logic [1:0] ctr_t;
  localparam ctr_t CTR_RESET = 2'b01;

  // Saturating step: 00 and 11 are sticky in their own direction.
  function automatic ctr_t ctr_next(ctr_t c, logic taken);
    ctr_t n;
    n = c;
    if (taken && c != 2'b11)
      n = ctr_t'(c + 2'd1);
    else if (!taken && c != 2'b00)
      n = ctr_t'(c - 2'd1);
    return n;
  endfunction

endpackage

// File: rtl/branch_bht.sv
// Branch history table: array of 2-bit saturating counters with one training
// port and one combinational read port (read returns the pre-update value).
module branch_bht
  import branch_pkg::*;
#(
  parameter  int BHT_ENTRIES = 16,
  localparam int IW          = $clog2(BHT_ENTRIES)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          upd_en,
  input  logic [IW-1:0] upd_idx,
  input  logic          upd_taken,
  input  logic [IW-1:0] rd_idx,
  output logic          rd_taken
);

  ctr_t r_ctr [BHT_ENTRIES];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < BHT_ENTRIES; i++)
        r_ctr[i] <= CTR_RESET;
    end else if (upd_en) begin
      r_ctr[upd_idx] <= ctr_next(r_ctr[upd_idx], upd_taken);
    end
  end

  assign rd_taken = r_ctr[rd_idx][1];

endmodule

// File: rtl/branch_unit.sv
// Branch/jump resolution stage: evaluates conditions and targets, registers the
// result behind a single-entry valid/ready slot, and trains the history table.
module branch_unit
  import branch_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int BHT_ENTRIES = 16,
  parameter int IALIGN      = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      in_kind,
  input  logic [2:0]      in_funct3,
  input  logic [XLEN-1:0] in_rs1,
  input  logic [XLEN-1:0] in_rs2,
  input  logic [XLEN-1:0] in_pc,
  input  logic [XLEN-1:0] in_imm,
  input  logic            in_pred_taken,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_next_pc,
  output logic [XLEN-1:0] out_link,
  output logic            out_taken,
  output logic            out_mispredict,
  output logic            out_misaligned,
  output logic            out_illegal,
  input  logic [XLEN-1:0] lookup_pc,
  output logic            lookup_taken
);

  localparam int AW = (IALIGN == 2) ? 1 : 2;
  localparam int IW = $clog2(BHT_ENTRIES);

  kind_t           w_kind;
  logic            w_is_br;
  logic            w_eq, w_lt, w_ltu;
  logic            w_cond, w_f3_bad;
  logic            w_illegal, w_taken, w_mispredict, w_misaligned;
  logic [XLEN-1:0] w_link, w_br_tgt, w_jalr_sum, w_target, w_next_pc;
  logic            w_accept, w_upd_en;
  logic            w_unused;

  logic            r_valid;
  logic [XLEN-1:0] r_next_pc, r_link;
  logic            r_taken, r_mispredict, r_misaligned, r_illegal;

  assign w_kind  = kind_t'(in_kind);
  assign w_is_br = (w_kind == BRANCH);

  assign w_eq  = (in_rs1 == in_rs2);
  assign w_lt  = ($signed(in_rs1) < $signed(in_rs2));
  assign w_ltu = (in_rs1 < in_rs2);

  always_comb begin
    w_cond   = 1'b0;
    w_f3_bad = 1'b0;
    case (in_funct3)
      F3_BEQ:  w_cond = w_eq;
      F3_BNE:  w_cond = !w_eq;
      F3_BLT:  w_cond = w_lt;
      F3_BGE:  w_cond = !w_lt;
      F3_BLTU: w_cond = w_ltu;
      F3_BGEU: w_cond = !w_ltu;
      default: w_f3_bad = 1'b1;
    endcase
  end

  // funct3 only carries a condition for conditional branches; jumps ignore it.
  assign w_illegal = (w_kind == RSVD) || (w_is_br && w_f3_bad);
  assign w_taken   = !w_illegal && (w_is_br ? w_cond : 1'b1);

  assign w_link     = in_pc + XLEN'(4);
  assign w_br_tgt   = in_pc + in_imm;
  assign w_jalr_sum = in_rs1 + in_imm;
  assign w_target   = (w_kind == JALR) ? {w_jalr_sum[XLEN-1:1], 1'b0} : w_br_tgt;
  assign w_next_pc  = w_taken ? w_target : w_link;

  assign w_misaligned = w_taken && (w_target[AW-1:0] != '0);
  assign w_mispredict = !w_illegal &&
                        (w_is_br ? (w_taken ^ in_pred_taken) : !in_pred_taken);

  assign in_ready = !rst && (!r_valid || out_ready);
  assign w_accept = in_valid && in_ready;
  assign w_upd_en = w_accept && w_is_br && !w_illegal;

  branch_bht #(.BHT_ENTRIES(BHT_ENTRIES)) u_bht (
    .clk       (clk),
    .rst       (rst),
    .upd_en    (w_upd_en),
    .upd_idx   (in_pc[AW +: IW]),
    .upd_taken (w_taken),
    .rd_idx    (lookup_pc[AW +: IW]),
    .rd_taken  (lookup_taken)
  );

  // Output slot: load on accept, otherwise empty once the consumer takes it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid      <= 1'b0;
      r_next_pc    <= '0;
      r_link       <= '0;
      r_taken      <= 1'b0;
      r_mispredict <= 1'b0;
      r_misaligned <= 1'b0;
      r_illegal    <= 1'b0;
    end else if (w_accept) begin
      r_valid      <= 1'b1;
      r_next_pc    <= w_next_pc;
      r_link       <= w_link;
      r_taken      <= w_taken;
      r_mispredict <= w_mispredict;
      r_misaligned <= w_misaligned;
      r_illegal    <= w_illegal;
    end else if (out_ready) begin
      r_valid      <= 1'b0;
    end
  end

  assign out_valid      = r_valid;
  assign out_next_pc    = r_next_pc;
  assign out_link       = r_link;
  assign out_taken      = r_taken;
  assign out_mispredict = r_mispredict;
  assign out_misaligned = r_misaligned;
  assign out_illegal    = r_illegal;

  assign w_unused = ^{lookup_pc, w_jalr_sum[0]};

endmodule

// File: doc/branch_unit.md
# branch_unit

Parametrised branch/jump resolution stage with a built-in branch history table (BHT). It accepts one control-transfer instruction per cycle over a valid/ready handshake and evaluates all six RISC-V conditional branches plus JAL/JALR. It returns a registered result: next PC, link value, taken, mispredict and exception flags. It also trains a table of 2-bit saturating counters that fetch queries through a combinational lookup port. It sits between decode/register-read and the PC-redirect logic.

## Interface
- `XLEN`, default 32: data/address width.
- `BHT_ENTRIES`, default 16: number of counters; power of two, ≥ 2.
- `IALIGN`, default 4: required target alignment in bytes; legal values are 4 and 2.

Clock and reset are fixed: one clock, `clk`; reset is synchronous and active-high, `rst`.

- `clk` in 1: clock.
- `rst` in 1: synchronous active-high reset.
- `in_valid` in 1: the input fields are valid.
- `in_ready` out 1: the unit can accept the input this cycle.
- `in_kind` in 2: 00 branch, 01 JAL, 10 JALR, 11 reserved (treated as illegal).
- `in_funct3` in 3: branch condition.
- `in_rs1`, `in_rs2` in XLEN: operands.
- `in_pc` in XLEN: instruction PC.
- `in_imm` in XLEN: sign-extended offset.
- `in_pred_taken` in 1: the direction fetch predicted.
- `out_valid` out 1: the result registers hold a result.
- `out_ready` in 1: the consumer accepts the result.
- `out_next_pc` out XLEN: resolved next PC.
- `out_link` out XLEN: `in_pc + 4`.
- `out_taken` out 1: the transfer was taken.
- `out_mispredict` out 1: resolved direction ≠ `in_pred_taken`.
- `out_misaligned` out 1: the taken target is not IALIGN-aligned.
- `out_illegal` out 1: reserved kind, or funct3 is 010 or 011.
- `lookup_pc` in XLEN: fetch PC to predict.
- `lookup_taken` out 1: MSB of the indexed counter.

## Operation
- **Accept:** an instruction is accepted when `in_valid && in_ready`. `in_ready = !out_valid || out_ready`, so the output acts as a single-entry pipeline register.
- **Conditions by funct3:**
  - 000 EQ, 001 NE.
  - 100 signed LT, 101 signed GE.
  - 110 unsigned LT, 111 unsigned GE.
- **JAL and JALR** are always taken.
- **Targets:**
  - Branch and JAL: `in_pc + in_imm`.
  - JALR: `(in_rs1 + in_imm) & ~1`.
  - All additions are modulo 2^XLEN; wrap-around is silent.
- **Next PC:** `out_next_pc` is the target if taken, else `in_pc + 4`.
- **Misaligned:** `out_misaligned = taken && target[log2(IALIGN)-1:0] != 0`. The target is still reported, and the BHT still trains.
- **Illegal:**
  - Forces `taken = 0`, `mispredict = 0` and `next_pc = in_pc + 4`.
  - No BHT update.
- **Mispredict:**
  - Branches: `taken ^ in_pred_taken`.
  - Jumps: `!in_pred_taken`.
- **BHT index:** `pc[log2(IALIGN) +: log2(BHT_ENTRIES)]`, used for both update and lookup.
- **BHT training:**
  - Happens only on accepted legal conditional branches.
  - The counter increments if taken and decrements if not, saturating at 00 and 11.
  - Jumps do not train the BHT.
- **Lookup:** the read is combinational and read-before-write. A lookup at the index being updated in the same cycle returns the pre-update counter.

## Timing
- Latency is 1 cycle: a result accepted at edge N is visible on `out_*` after edge N with `out_valid=1`.
- `out_*` holds stable while `out_valid && !out_ready`.
- Simultaneous drain and accept (`out_ready=1`, `in_valid=1`) loads the new result with no bubble. Sustained throughput is 1 per cycle.
- `out_valid` drops after the edge where `out_ready=1` and there is no new accept.
- **Reset values:**
  - `out_valid=0`.
  - All `out_*` data outputs 0.
  - All counters 01 (weakly not-taken), so `lookup_taken=0`.
- **Reset mid-operation:** `rst` wins over everything in that cycle. An input presented during reset is dropped, the held result is discarded, and there is no BHT update. `in_ready=0` while `rst=1`.

## Structure
- Package `branch_pkg` holds:
  - the `kind_t` enum (BRANCH, JAL, JALR, RSVD);
  - funct3 constants (F3_BEQ … F3_BGEU);
  - `ctr_t` (2-bit), with `CTR_RESET = 2'b01`.
- Sub-module `branch_bht` (parameter `BHT_ENTRIES`):
  - ports: `clk`, `rst`, `upd_en`, `upd_idx`, `upd_taken`, `rd_idx`, `rd_taken`;
  - contains the counter array and saturation logic.
- The top level holds the compare logic, target adders and output register.

## Test plan
- **Compare, all conditions:** rs1=0xFFFFFFFF, rs2=1, pc=0x100, imm=0x20, pred=0, one instruction per cycle for funct3 000,001,100,101,110,111.
  - Taken = 0,1,1,0,0,1.
  - next_pc is 0x120 when taken, 0x104 otherwise.
  - Mispredict equals taken.
- **JALR:** rs1=0x1003, imm=2, pc=0x40, pred=1.
  - next_pc=0x1004, link=0x44, taken=1, mispredict=0.
  - misaligned=0 with IALIGN=4? No: target 0x1004 is aligned, so 0 at both settings.
- **Misaligned JAL:** pc=0x200, imm=6.
  - IALIGN=4: misaligned=1, next_pc=0x206.
  - IALIGN=2: misaligned=0.
- **Training and saturation:** four taken BEQ at pc=0x80.
  - Before the first: lookup_taken(0x80)=0.
  - After the first: 1.
  - Counter saturates at 11.
  - Then two not-taken: the first leaves lookup=1, the second gives 0.
  - Same-cycle lookup during an update returns the old value.
- **Backpressure and illegal:** hold out_ready=0 for 3 cycles with in_valid=1.
  - in_ready=0 and out_* stable during the hold.
  - Releasing gives back-to-back results.
  - funct3=010 gives illegal=1, taken=0, next_pc=pc+4, counter unchanged.
- **Reset mid-stream:** assert rst with out_valid=1 and counters trained.
  - Next cycle: out_valid=0, all counters read 01, the input accepted during reset is not seen.
